// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter (imem_arb).
package imem_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} arb_state_e;
   typedef enum logic {OWN_FETCH = 1'b0, OWN_LOAD = 1'b1} owner_e;
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;
endpackage

// File: rtl/imem_arb_rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers the last winner so a tie
// goes to the other side. Reset points at the loader so fetch wins the first tie.
module rr_arb2 (
   input  logic clk,
   input  logic reset,
   input  logic i_req_f,
   input  logic i_req_l,
   output logic o_gnt_f,
   output logic o_gnt_l
);
   import imem_pkg::*;

   owner_e r_last;

   // Grant decode: tie broken against the previous winner
   always_comb begin
      o_gnt_f = 1'b0;
      o_gnt_l = 1'b0;
      if (i_req_f && i_req_l) begin
         if (r_last == OWN_LOAD) begin
            o_gnt_f = 1'b1;
         end else begin
            o_gnt_l = 1'b1;
         end
      end else begin
         o_gnt_f = i_req_f;
         o_gnt_l = i_req_l;
      end
   end

   // Last-grant pointer, updated on every grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last <= OWN_LOAD;
      end else if (o_gnt_f) begin
         r_last <= OWN_FETCH;
      end else if (o_gnt_l) begin
         r_last <= OWN_LOAD;
      end
   end
endmodule

// File: rtl/imem_arb.sv
// Fetch/loader arbiter for a shared single-port instruction memory with a loader lock.
// Optional macro IMEM_ARB_RANGECHK_EN: bad addresses return a NOP and pulse err_pulse.
module imem_arb #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          f_req,
   input  logic [31:0]   f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [31:0]   f_rdata,
   output logic          f_stall,
   input  logic          l_req,
   input  logic          l_we,
   input  logic          l_lock,
   input  logic [31:0]   l_addr,
   input  logic [31:0]   l_wdata,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic [31:0]   l_rdata,
   output logic [AW-1:0] m_addr,
   output logic          m_we,
   output logic [31:0]   m_wdata,
   input  logic [31:0]   m_rdata
`ifdef IMEM_ARB_RANGECHK_EN
   ,
   output logic          err_pulse
`endif
);
   import imem_pkg::*;

   arb_state_e  r_state;
   logic        r_f_rvalid;
   logic        r_l_rvalid;
   logic [31:0] r_f_rdata;
   logic [31:0] r_l_rdata;
   logic        w_req_f;
   logic        w_gnt_f;
   logic        w_gnt_l;
   logic        w_f_bad;
   logic        w_l_bad;
   logic        w_bad;
   logic [31:0] w_rsp;

   // Fetch is masked entirely while the loader holds the lock
   assign w_req_f = f_req && (r_state == ST_IDLE);

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .reset   (reset),
      .i_req_f (w_req_f),
      .i_req_l (l_req),
      .o_gnt_f (w_gnt_f),
      .o_gnt_l (w_gnt_l)
   );

   assign f_gnt   = w_gnt_f;
   assign l_gnt   = w_gnt_l;
   assign f_stall = f_req & ~w_gnt_f;
   assign m_wdata = l_wdata;

`ifdef IMEM_ARB_RANGECHK_EN
   logic r_err;
   logic w_unused_depth;
   assign w_f_bad        = (|f_addr[31:AW+2]) | (|f_addr[1:0]);
   assign w_l_bad        = (|l_addr[31:AW+2]) | (|l_addr[1:0]);
   assign err_pulse      = r_err;
   assign w_unused_depth = (DEPTH > 0);

   // Error flag rides alongside the response it belongs to
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_bad;
      end
   end
`else
   logic w_unused_bits;
   assign w_f_bad       = 1'b0;
   assign w_l_bad       = 1'b0;
   assign w_unused_bits = ^{f_addr[31:AW+2], f_addr[1:0], l_addr[31:AW+2], l_addr[1:0], (DEPTH > 0)};
`endif

   // Memory-side mux; a rejected loader access never writes
   always_comb begin
      m_addr = f_addr[AW+1:2];
      m_we   = 1'b0;
      w_bad  = 1'b0;
      if (w_gnt_l) begin
         m_addr = l_addr[AW+1:2];
         m_we   = l_we & ~w_l_bad;
         w_bad  = w_l_bad;
      end else if (w_gnt_f) begin
         w_bad  = w_f_bad;
      end else begin
         w_bad  = 1'b0;
      end
   end

   always_comb begin
      w_rsp = m_rdata;
      if (w_bad) begin
         w_rsp = NOP_INSN;
      end else if (w_gnt_l && l_we) begin
         w_rsp = 32'h0000_0000;
      end else begin
         w_rsp = m_rdata;
      end
   end

   // Lock FSM: lock only taken together with a granted loader access
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:   if (w_gnt_l && l_lock) r_state <= ST_LOCKED;
            ST_LOCKED: if (!l_lock)           r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   // One-cycle response; rdata holds between pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_f_rvalid <= 1'b0;
         r_l_rvalid <= 1'b0;
         r_f_rdata  <= 32'h0000_0000;
         r_l_rdata  <= 32'h0000_0000;
      end else begin
         r_f_rvalid <= w_gnt_f;
         r_l_rvalid <= w_gnt_l;
         if (w_gnt_f) r_f_rdata <= w_rsp;
         if (w_gnt_l) r_l_rdata <= w_rsp;
      end
   end

   assign f_rvalid = r_f_rvalid;
   assign f_rdata  = r_f_rdata;
   assign l_rvalid = r_l_rvalid;
   assign l_rdata  = r_l_rdata;
endmodule

// File: tb/tb_imem_arb.sv
// Table-driven bench for imem_arb with a response scoreboard and a behavioural memory.
module tb_imem_arb;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk;
   logic          reset;
   logic          f_req, f_gnt, f_rvalid, f_stall;
   logic [31:0]   f_addr, f_rdata;
   logic          l_req, l_we, l_lock, l_gnt, l_rvalid;
   logic [31:0]   l_addr, l_wdata, l_rdata;
   logic [AW-1:0] m_addr;
   logic          m_we;
   logic [31:0]   m_wdata, m_rdata;
`ifdef IMEM_ARB_RANGECHK_EN
   logic          err_pulse;
`endif

   logic [31:0] mem     [0:DEPTH-1];
   logic [31:0] ref_mem [0:DEPTH-1];
   logic        mem_init;

   typedef struct {
      logic          f_req;
      logic [31:0]   f_addr;
      logic          l_req;
      logic          l_we;
      logic          l_lock;
      logic [31:0]   l_addr;
      logic [31:0]   l_wdata;
      logic          exp_fg;
      logic          exp_lg;
      logic [AW-1:0] exp_maddr;
   } vec_t;

   typedef struct {
      logic        is_load;
      logic [31:0] data;
   } rsp_t;

   vec_t        vecs[$];
   rsp_t        exp_q[$];
   logic [31:0] last_f, last_l;
   int          n_tests = 0;
   int          n_fail  = 0;

   imem_arb #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .f_req    (f_req),
      .f_addr   (f_addr),
      .f_gnt    (f_gnt),
      .f_rvalid (f_rvalid),
      .f_rdata  (f_rdata),
      .f_stall  (f_stall),
      .l_req    (l_req),
      .l_we     (l_we),
      .l_lock   (l_lock),
      .l_addr   (l_addr),
      .l_wdata  (l_wdata),
      .l_gnt    (l_gnt),
      .l_rvalid (l_rvalid),
      .l_rdata  (l_rdata),
      .m_addr   (m_addr),
      .m_we     (m_we),
      .m_wdata  (m_wdata),
      .m_rdata  (m_rdata)
`ifdef IMEM_ARB_RANGECHK_EN
      ,
      .err_pulse(err_pulse)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign m_rdata = mem[m_addr];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= {16'hC0DE, 16'(i)};
      end else if (m_we) begin
         mem[m_addr] <= m_wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      f_req = 1'b0; f_addr = 32'h0; l_req = 1'b0; l_we = 1'b0;
      l_lock = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
   endtask

   function automatic vec_t mk(input logic fr, input logic [31:0] fa, input logic lr,
                               input logic lw, input logic lk, input logic [31:0] la,
                               input logic [31:0] ld, input logic efg, input logic elg,
                               input logic [AW-1:0] ema);
      vec_t v;
      v.f_req = fr; v.f_addr = fa; v.l_req = lr; v.l_we = lw; v.l_lock = lk;
      v.l_addr = la; v.l_wdata = ld; v.exp_fg = efg; v.exp_lg = elg; v.exp_maddr = ema;
      return v;
   endfunction

   task automatic check_rsp(input string tag);
      rsp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_f_rvalid"}, {31'h0, f_rvalid}, {31'h0, ~e.is_load});
         chk({tag, "_l_rvalid"}, {31'h0, l_rvalid}, {31'h0, e.is_load});
         if (e.is_load) begin
            chk({tag, "_l_rdata"}, l_rdata, e.data);
            last_l = e.data;
         end else begin
            chk({tag, "_f_rdata"}, f_rdata, e.data);
            last_f = e.data;
         end
      end else begin
         chk({tag, "_f_rvalid_idle"}, {31'h0, f_rvalid}, 32'h0);
         chk({tag, "_l_rvalid_idle"}, {31'h0, l_rvalid}, 32'h0);
         chk({tag, "_f_rdata_hold"}, f_rdata, last_f);
         chk({tag, "_l_rdata_hold"}, l_rdata, last_l);
      end
   endtask

   task automatic apply_vec(input int idx, input vec_t v);
      string tag;
      rsp_t  r;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      f_req = v.f_req; f_addr = v.f_addr; l_req = v.l_req; l_we = v.l_we;
      l_lock = v.l_lock; l_addr = v.l_addr; l_wdata = v.l_wdata;
      #1;
      chk({tag, "_f_gnt"}, {31'h0, f_gnt}, {31'h0, v.exp_fg});
      chk({tag, "_l_gnt"}, {31'h0, l_gnt}, {31'h0, v.exp_lg});
      chk({tag, "_f_stall"}, {31'h0, f_stall}, {31'h0, v.f_req & ~v.exp_fg});
      chk({tag, "_m_we"}, {31'h0, m_we}, {31'h0, v.exp_lg & v.l_we});
      if (v.exp_fg || v.exp_lg) chk({tag, "_m_addr"}, {26'h0, m_addr}, {26'h0, v.exp_maddr});
      if (v.exp_lg && v.l_we) begin
         chk({tag, "_m_wdata"}, m_wdata, v.l_wdata);
         r.is_load = 1'b1; r.data = 32'h0;
         ref_mem[v.exp_maddr] = v.l_wdata;
         exp_q.push_back(r);
      end else if (v.exp_lg || v.exp_fg) begin
         r.is_load = v.exp_lg; r.data = ref_mem[v.exp_maddr];
         exp_q.push_back(r);
      end
      @(posedge clk); #1;
      check_rsp(tag);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_f_rvalid"}, {31'h0, f_rvalid}, 32'h0);
      chk({tag, "_l_rvalid"}, {31'h0, l_rvalid}, 32'h0);
      chk({tag, "_f_rdata"}, f_rdata, 32'h0);
      chk({tag, "_l_rdata"}, l_rdata, 32'h0);
   endtask

   initial begin
      drive_idle();
      reset = 1'b1; mem_init = 1'b1;
      last_f = 32'h0; last_l = 32'h0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = {16'hC0DE, 16'(i)};
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("rst");
      chk("rst_f_gnt", {31'h0, f_gnt}, 32'h0);
      @(negedge clk);
      mem_init = 1'b0; reset = 1'b0;

      //          f_req fa           l_req we  lk   la           ld            fg   lg   ma
      vecs.push_back(mk(1'b1, 32'h00, 1'b1, 1'b0, 1'b0, 32'h04, 32'h0,         1'b1, 1'b0, 6'd0));
      vecs.push_back(mk(1'b1, 32'h0C, 1'b1, 1'b0, 1'b0, 32'h04, 32'h0,         1'b0, 1'b1, 6'd1));
      vecs.push_back(mk(1'b1, 32'h0C, 1'b1, 1'b0, 1'b0, 32'h04, 32'h0,         1'b1, 1'b0, 6'd3));
      vecs.push_back(mk(1'b1, 32'h0C, 1'b1, 1'b0, 1'b0, 32'h18, 32'h0,         1'b0, 1'b1, 6'd6));
      vecs.push_back(mk(1'b1, 32'h08, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,         1'b1, 1'b0, 6'd2));
      vecs.push_back(mk(1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h14, 32'h12345678,  1'b0, 1'b1, 6'd5));
      vecs.push_back(mk(1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,         1'b1, 1'b0, 6'd5));
      vecs.push_back(mk(1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,         1'b0, 1'b0, 6'd0));
      vecs.push_back(mk(1'b1, 32'h1C, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0,         1'b0, 1'b1, 6'd8));
      vecs.push_back(mk(1'b1, 32'h04, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,         1'b1, 1'b0, 6'd1));
      vecs.push_back(mk(1'b1, 32'h04, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,         1'b1, 1'b0, 6'd1));
      vecs.push_back(mk(1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF,  1'b0, 1'b1, 6'd4));
      vecs.push_back(mk(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,         1'b0, 1'b0, 6'd0));
      vecs.push_back(mk(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0,         1'b0, 1'b1, 6'd4));
      vecs.push_back(mk(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,         1'b0, 1'b0, 6'd0));
      vecs.push_back(mk(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,         1'b1, 1'b0, 6'd4));
      vecs.push_back(mk(1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,         1'b0, 1'b0, 6'd0));

      foreach (vecs[i]) apply_vec(i, vecs[i]);
      chk("mem4_written", mem[4], 32'hDEADBEEF);

      // Reset lands inside the grant cycle: the response must never appear
      @(negedge clk);
      f_req = 1'b1; f_addr = 32'h08;
      #1;
      chk("mid_f_gnt", {31'h0, f_gnt}, 32'h1);
      #2 reset = 1'b1;
      #1 f_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         check_reset_state($sformatf("midrst%0d", k));
      end
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete(); last_f = 32'h0; last_l = 32'h0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         check_rsp($sformatf("post%0d", k));
      end

      // First tie after reset goes to fetch, granted in the first cycle
      apply_vec(100, mk(1'b1, 32'h08, 1'b1, 1'b0, 1'b0, 32'h0C, 32'h0, 1'b1, 1'b0, 6'd2));
      apply_vec(101, mk(1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 6'd0));

`ifdef IMEM_ARB_RANGECHK_EN
      @(negedge clk);
      f_req = 1'b1; f_addr = 32'h400;
      #1;
      chk("rc_f_gnt", {31'h0, f_gnt}, 32'h1);
      chk("rc_m_we", {31'h0, m_we}, 32'h0);
      @(posedge clk); #1;
      chk("rc_f_rvalid", {31'h0, f_rvalid}, 32'h1);
      chk("rc_f_rdata", f_rdata, 32'h0000_0013);
      chk("rc_err", {31'h0, err_pulse}, 32'h1);
      @(negedge clk);
      f_req = 1'b0;
      @(posedge clk); #1;
      chk("rc_err_clear", {31'h0, err_pulse}, 32'h0);
`else
      @(negedge clk);
      f_req = 1'b1; f_addr = 32'h400;
      #1;
      chk("trunc_f_gnt", {31'h0, f_gnt}, 32'h1);
      chk("trunc_m_addr", {26'h0, m_addr}, 32'h0);
      @(posedge clk); #1;
      chk("trunc_f_rvalid", {31'h0, f_rvalid}, 32'h1);
      chk("trunc_f_rdata", f_rdata, ref_mem[0]);
      @(negedge clk);
      f_req = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
